// File: rtl/seg_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bus layout and
// the encoding of the data-memory access FSM.
package seg_pkg;

   localparam int unsigned NB_CTRL_WB = 2;
   localparam int unsigned NB_CTRL_M  = 3;

   localparam int unsigned CTRL_M_BRANCH    = 2;
   localparam int unsigned CTRL_M_MEMREAD   = 1;
   localparam int unsigned CTRL_M_MEMWRITE  = 0;
   localparam int unsigned CTRL_WB_REGWRITE = 1;
   localparam int unsigned CTRL_WB_MEMTOREG = 0;

   typedef enum logic {
      StIdle = 1'b0,
      StWait = 1'b1
   } mem_state_e;

endpackage

// File: rtl/seg_memory_access_fsm.sv
// IDLE/WAIT handshake tracker for the data-memory port: generates request,
// stall, completion and abort (timeout or misaligned access).
module seg_memory_access_fsm
   import seg_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_memop,
   input  logic i_misalign,
   input  logic i_mem_ack,
   output logic o_mem_req,
   output logic o_stall,
   output logic o_done,
   output logic o_abort
);

   mem_state_e r_state;
   logic [7:0] r_cnt;
   logic       w_timeout;

   // Last permitted wait cycle without ack: abort and release the pipeline.
   assign w_timeout = (r_state == StWait) & ~i_mem_ack & (r_cnt == 8'(TIMEOUT));

   assign o_mem_req = i_memop & ~i_misalign;
   assign o_done    = o_mem_req & i_mem_ack;
   assign o_abort   = (i_memop & i_misalign) | (o_mem_req & w_timeout);
   assign o_stall   = o_mem_req & ~i_mem_ack & ~w_timeout;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cnt   <= 8'd0;
      end else begin
         case (r_state)
            StIdle: begin
               if (o_mem_req & ~i_mem_ack) begin
                  r_state <= StWait;
                  r_cnt   <= 8'd1;
               end
            end
            StWait: begin
               if (i_mem_ack | w_timeout) begin
                  r_state <= StIdle;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_cnt   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/seg_memory.sv
// MEM stage: EX/MEM register, branch resolution, req/ack load/store, MEM/WB register.
// Define SEG_MEMORY_ALIGN_CHECK_EN to retire misaligned accesses as bus errors.
module seg_memory
   import seg_pkg::*;
#(
   parameter int unsigned LEN        = 32,
   parameter int unsigned NB_ADDR    = 5,
   parameter int unsigned NB_CTRL_WB = 2,
   parameter int unsigned NB_CTRL_M  = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [LEN-1:0]        i_PC_branch,
   input  logic [LEN-1:0]        i_ALU_result,
   input  logic [LEN-1:0]        i_write_data,
   input  logic [NB_ADDR-1:0]    i_write_register,
   input  logic                  i_ALU_zero,
   input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
   input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
   input  logic                  i_mem_ack,
   input  logic [LEN-1:0]        i_mem_rdata,
   output logic                  o_stall,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [LEN-1:0]        o_mem_addr,
   output logic [LEN-1:0]        o_mem_wdata,
   output logic                  o_PCSrc,
   output logic [LEN-1:0]        o_PC_branch,
   output logic                  o_valid,
   output logic [LEN-1:0]        o_read_data,
   output logic [LEN-1:0]        o_ALU_result,
   output logic [NB_ADDR-1:0]    o_write_register,
   output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
   output logic                  o_bus_error
);

   logic                  r_exm_valid;
   logic [LEN-1:0]        r_exm_pc_branch;
   logic [LEN-1:0]        r_exm_alu;
   logic [LEN-1:0]        r_exm_wdata;
   logic [NB_ADDR-1:0]    r_exm_wreg;
   logic                  r_exm_zero;
   logic [NB_CTRL_WB-1:0] r_exm_wb;
   logic [NB_CTRL_M-1:0]  r_exm_m;

   logic                  w_memop;
   logic                  w_misalign;
   logic                  w_stall;
   logic                  w_done;
   logic                  w_abort;
   logic [NB_CTRL_WB-1:0] w_wb_next;

   assign w_memop = r_exm_valid & (r_exm_m[CTRL_M_MEMREAD] | r_exm_m[CTRL_M_MEMWRITE]);

`ifdef SEG_MEMORY_ALIGN_CHECK_EN
   assign w_misalign = (r_exm_alu[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   seg_memory_access_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_access_fsm (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_memop    (w_memop),
      .i_misalign (w_misalign),
      .i_mem_ack  (i_mem_ack),
      .o_mem_req  (o_mem_req),
      .o_stall    (w_stall),
      .o_done     (w_done),
      .o_abort    (w_abort)
   );

   assign o_stall     = w_stall;
   assign o_mem_we    = r_exm_m[CTRL_M_MEMWRITE];
   assign o_mem_addr  = r_exm_alu;
   assign o_mem_wdata = r_exm_wdata;
   assign o_PCSrc     = r_exm_valid & r_exm_m[CTRL_M_BRANCH] & r_exm_zero;
   assign o_PC_branch = r_exm_pc_branch;

   // An aborted instruction must not write the register file.
   always_comb begin
      w_wb_next = r_exm_wb;
      if (w_abort) begin
         w_wb_next[CTRL_WB_REGWRITE] = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_exm_valid     <= 1'b0;
         r_exm_pc_branch <= '0;
         r_exm_alu       <= '0;
         r_exm_wdata     <= '0;
         r_exm_wreg      <= '0;
         r_exm_zero      <= 1'b0;
         r_exm_wb        <= '0;
         r_exm_m         <= '0;
      end else if (!w_stall) begin
         r_exm_valid     <= i_valid;
         r_exm_pc_branch <= i_PC_branch;
         r_exm_alu       <= i_ALU_result;
         r_exm_wdata     <= i_write_data;
         r_exm_wreg      <= i_write_register;
         r_exm_zero      <= i_ALU_zero;
         r_exm_wb        <= i_valid ? i_ctrl_wb_bus : '0;
         r_exm_m         <= i_valid ? i_ctrl_mem_bus : '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid          <= 1'b0;
         o_read_data      <= '0;
         o_ALU_result     <= '0;
         o_write_register <= '0;
         o_ctrl_wb_bus    <= '0;
         o_bus_error      <= 1'b0;
      end else begin
         o_bus_error <= w_abort;
         if (w_stall) begin
            o_valid       <= 1'b0;
            o_ctrl_wb_bus <= '0;
         end else begin
            o_valid          <= r_exm_valid & ~w_abort;
            o_read_data      <= (w_done & ~r_exm_m[CTRL_M_MEMWRITE]) ? i_mem_rdata : '0;
            o_ALU_result     <= r_exm_alu;
            o_write_register <= r_exm_wreg;
            o_ctrl_wb_bus    <= w_wb_next;
         end
      end
   end

endmodule
